// File: rtl/ic_diag_ctl_if.sv
// ic_diag_ctl_if
// Bundles every non-clock signal of the icache diagnostic controller:
//   - TLU request side : req_valid/req_ready/req_wr/req_tag/req_way/req_addr/req_wdata
//   - TLU response side: resp_valid/resp_rdata
//   - fetch arbitration: fetch_req (in), fetch_stall (out)
//   - icache debug port: ic_debug_rd_en/wr_en/tag_array/way/addr/wr_data (out),
//                        ic_debug_rd_data (in)
//   - status           : busy
// Modport slave is the controller's view; master is the surrounding IFU/TLU view.
interface ic_diag_ctl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64,
    parameter int WAYS   = 4
);
    localparam int WAY_W = $clog2(WAYS);

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic              req_tag;
    logic [WAY_W-1:0]  req_way;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;

    logic              fetch_req;
    logic              fetch_stall;

    logic              ic_debug_rd_en;
    logic              ic_debug_wr_en;
    logic              ic_debug_tag_array;
    logic [WAYS-1:0]   ic_debug_way;
    logic [ADDR_W-1:0] ic_debug_addr;
    logic [DATA_W-1:0] ic_debug_wr_data;
    logic [DATA_W-1:0] ic_debug_rd_data;

    logic              busy;

    modport slave (
        input  req_valid, req_wr, req_tag, req_way, req_addr, req_wdata,
        input  fetch_req, ic_debug_rd_data,
        output req_ready, resp_valid, resp_rdata, fetch_stall,
        output ic_debug_rd_en, ic_debug_wr_en, ic_debug_tag_array,
        output ic_debug_way, ic_debug_addr, ic_debug_wr_data, busy
    );

    modport master (
        output req_valid, req_wr, req_tag, req_way, req_addr, req_wdata,
        output fetch_req, ic_debug_rd_data,
        input  req_ready, resp_valid, resp_rdata, fetch_stall,
        input  ic_debug_rd_en, ic_debug_wr_en, ic_debug_tag_array,
        input  ic_debug_way, ic_debug_addr, ic_debug_wr_data, busy
    );
endinterface

// File: rtl/ic_diag_ctl.sv
// ic_diag_ctl
// Sequences single icache diagnostic read/write requests from the TLU onto the
// icache tag/data array debug port, sharing that port with instruction fetch.
// A request waits in ARB while fetch owns the port; after STARVE_LIMIT blocked
// cycles the controller raises fetch_stall to take the port.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   dbg - ic_diag_ctl_if.slave (request/response, fetch arbitration,
//         icache debug array port, busy)
module ic_diag_ctl #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 64,
    parameter int WAYS         = 4,
    parameter int RD_LAT       = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    ic_diag_ctl_if.slave dbg
);

    localparam int WAY_W = $clog2(WAYS);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam int LC_W  = $clog2(RD_LAT + 1);

    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [LC_W-1:0] LAT_LOAD   = LC_W'(RD_LAT);
    localparam logic [LC_W-1:0] LAT_LAST   = LC_W'(1);
    localparam logic [WAYS-1:0] WAY_ONE    = {{(WAYS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_ISSUE,
        S_RD_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic              tag_q, tag_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic              stall_q, stall_d;
    logic [LC_W-1:0]   lat_q, lat_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    logic              issue;
    logic              grant;

    // Fetch yields the port either on its own or because we are stalling it.
    assign grant = !dbg.fetch_req || stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_q         <= 1'b0;
            tag_q        <= 1'b0;
            way_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            starve_q     <= '0;
            stall_q      <= 1'b0;
            lat_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            tag_q        <= tag_d;
            way_q        <= way_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            starve_q     <= starve_d;
            stall_q      <= stall_d;
            lat_q        <= lat_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        tag_d        = tag_q;
        way_d        = way_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        starve_d     = starve_q;
        stall_d      = stall_q;
        lat_d        = lat_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (dbg.req_valid) begin
                    wr_d    = dbg.req_wr;
                    tag_d   = dbg.req_tag;
                    way_d   = dbg.req_way;
                    addr_d  = dbg.req_addr;
                    wdata_d = dbg.req_wdata;
                    state_d = S_ARB;
                end
            end

            S_ARB: begin
                // Once the counter has saturated, the next blocked cycle
                // registers the stall; the grant lands one cycle later.
                if (grant) begin
                    starve_d = '0;
                    state_d  = S_ISSUE;
                end else if (starve_q == STARVE_MAX) begin
                    stall_d = 1'b1;
                end else begin
                    starve_d = starve_q + SC_W'(1);
                end
            end

            S_ISSUE: begin
                if (wr_q) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    stall_d      = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    lat_d   = LAT_LOAD;
                    state_d = S_RD_WAIT;
                end
            end

            S_RD_WAIT: begin
                // lat_q reaches 1 in the cycle the array presents read data.
                if (lat_q == LAT_LAST) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = dbg.ic_debug_rd_data;
                    stall_d      = 1'b0;
                    lat_d        = '0;
                    state_d      = S_IDLE;
                end else begin
                    lat_d = lat_q - LC_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign issue = (state_q == S_ISSUE);

    assign dbg.req_ready          = (state_q == S_IDLE) && !rst;
    assign dbg.busy               = (state_q != S_IDLE);
    assign dbg.fetch_stall        = stall_q;
    assign dbg.resp_valid         = resp_valid_q;
    assign dbg.resp_rdata         = resp_rdata_q;

    // The array port is driven only during ISSUE and is otherwise held at 0.
    assign dbg.ic_debug_rd_en     = issue && !wr_q;
    assign dbg.ic_debug_wr_en     = issue && wr_q;
    assign dbg.ic_debug_tag_array = issue && tag_q;
    assign dbg.ic_debug_way       = issue ? (WAY_ONE << way_q) : '0;
    assign dbg.ic_debug_addr      = issue ? addr_q : '0;
    assign dbg.ic_debug_wr_data   = issue ? wdata_q : '0;

endmodule

// File: tb/tb_ic_diag_ctl.sv
// tb_ic_diag_ctl
// Drives ic_diag_ctl through directed scenarios and a randomized phase, and
// compares every output every cycle against a transaction-level model that
// derives grant, issue and response cycles from the acceptance cycle and the
// observed fetch_req history.
module tb_ic_diag_ctl;

    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 64;
    localparam int WAYS         = 4;
    localparam int RD_LAT       = 2;
    localparam int STARVE_LIMIT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ic_diag_ctl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS)) dbg ();

    ic_diag_ctl #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WAYS        (WAYS),
        .RD_LAT      (RD_LAT),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dbg(dbg)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Transaction model: an active op is described by its acceptance cycle
    // m_t and its grant cycle m_g (-1 until fetch lets go or the stall wins).
    bit          m_act   = 1'b0;
    int          m_t     = 0;
    int          m_g     = -1;
    logic        m_wr    = 1'b0;
    logic        m_tag   = 1'b0;
    logic [1:0]  m_way   = '0;
    logic [15:0] m_addr  = '0;
    logic [63:0] m_wdata = '0;
    logic        m_rv    = 1'b0;
    logic [63:0] m_rd    = '0;

    int          obs_rd_en_cyc, obs_wr_en_cyc, obs_wr_en_cnt;
    int          obs_resp_cyc, obs_first_resp, obs_resp_cnt;
    int          obs_stall_rise, obs_stall_fall, obs_accept_cyc;
    logic [3:0]  obs_way;
    logic        obs_tag;
    logic [63:0] obs_wdata, obs_resp_data;
    logic        prev_stall = 1'b0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_obs();
        obs_rd_en_cyc  = -1;
        obs_wr_en_cyc  = -1;
        obs_wr_en_cnt  = 0;
        obs_resp_cyc   = -1;
        obs_first_resp = -1;
        obs_resp_cnt   = 0;
        obs_stall_rise = -1;
        obs_stall_fall = -1;
        obs_accept_cyc = -1;
        obs_way        = '0;
        obs_tag        = 1'b0;
        obs_wdata      = '0;
        obs_resp_data  = '0;
    endtask

    task automatic applyStimulus(input logic v, input logic wr, input logic tag,
                                 input logic [1:0] way, input logic [15:0] addr,
                                 input logic [63:0] wdata);
        dbg.req_valid = v;
        dbg.req_wr    = wr;
        dbg.req_tag   = tag;
        dbg.req_way   = way;
        dbg.req_addr  = addr;
        dbg.req_wdata = wdata;
    endtask

    task automatic checkOutput();
        logic e_issue;
        logic e_stall;
        if (m_act && m_g < 0 && cyc > m_t) begin
            if (!dbg.fetch_req || (cyc - m_t) >= STARVE_LIMIT + 2)
                m_g = cyc;
        end
        e_issue = m_act && (m_g >= 0) && (cyc == m_g + 1);
        e_stall = m_act && (m_g >= 0) && (m_g == m_t + STARVE_LIMIT + 2);

        cmp("req_ready",   64'(dbg.req_ready),          64'(!m_act && !rst));
        cmp("busy",        64'(dbg.busy),               64'(m_act));
        cmp("fetch_stall", 64'(dbg.fetch_stall),        64'(e_stall));
        cmp("rd_en",       64'(dbg.ic_debug_rd_en),     64'(e_issue && !m_wr));
        cmp("wr_en",       64'(dbg.ic_debug_wr_en),     64'(e_issue && m_wr));
        cmp("tag_array",   64'(dbg.ic_debug_tag_array), 64'(e_issue && m_tag));
        cmp("way",         64'(dbg.ic_debug_way),       e_issue ? 64'(4'b0001 << m_way) : 64'd0);
        cmp("addr",        64'(dbg.ic_debug_addr),      e_issue ? 64'(m_addr) : 64'd0);
        cmp("wr_data",     dbg.ic_debug_wr_data,        e_issue ? m_wdata : 64'd0);
        cmp("resp_valid",  64'(dbg.resp_valid),         64'(m_rv));
        cmp("resp_rdata",  dbg.resp_rdata,              m_rd);

        if (dbg.ic_debug_rd_en === 1'b1) begin
            obs_rd_en_cyc = cyc;
            obs_way       = dbg.ic_debug_way;
        end
        if (dbg.ic_debug_wr_en === 1'b1) begin
            obs_wr_en_cyc = cyc;
            obs_wr_en_cnt++;
            obs_way       = dbg.ic_debug_way;
            obs_tag       = dbg.ic_debug_tag_array;
            obs_wdata     = dbg.ic_debug_wr_data;
        end
        if (dbg.resp_valid === 1'b1) begin
            if (obs_resp_cnt == 0) obs_first_resp = cyc;
            obs_resp_cyc  = cyc;
            obs_resp_cnt++;
            obs_resp_data = dbg.resp_rdata;
        end
        if (dbg.fetch_stall === 1'b1 && !prev_stall) obs_stall_rise = cyc;
        if (dbg.fetch_stall !== 1'b1 && prev_stall)  obs_stall_fall = cyc;
        prev_stall = (dbg.fetch_stall === 1'b1);
        if (dbg.req_ready === 1'b1 && dbg.req_valid) obs_accept_cyc = cyc;

        // Advance the model across the coming clock edge.
        if (rst) begin
            m_act = 1'b0;
            m_rv  = 1'b0;
            m_rd  = '0;
        end else begin
            m_rv = 1'b0;
            if (m_act) begin
                if (m_g >= 0 && m_wr && cyc == m_g + 1) begin
                    m_rv  = 1'b1;
                    m_rd  = '0;
                    m_act = 1'b0;
                end else if (m_g >= 0 && !m_wr && cyc == m_g + 1 + RD_LAT) begin
                    m_rv  = 1'b1;
                    m_rd  = dbg.ic_debug_rd_data;
                    m_act = 1'b0;
                end
            end else if (dbg.req_valid) begin
                m_act   = 1'b1;
                m_t     = cyc;
                m_g     = -1;
                m_wr    = dbg.req_wr;
                m_tag   = dbg.req_tag;
                m_way   = dbg.req_way;
                m_addr  = dbg.req_addr;
                m_wdata = dbg.req_wdata;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Runs the active op to completion, then ticks through its response cycle.
    task automatic finish_op(input int t, input int block);
        int n;
        n = 0;
        while (m_act && n < 60) begin
            dbg.fetch_req = ((cyc - t) >= 1) && ((cyc - t) <= block);
            tick();
            n++;
        end
        if (m_act) begin
            checks++;
            errors++;
            $display("[TB] FAIL op_timeout cycle %0d: got busy expected done", cyc);
        end
        dbg.fetch_req = 1'b0;
        tick();
    endtask

    task automatic do_op(input logic wr, input logic tag, input logic [1:0] way,
                         input logic [15:0] addr, input logic [63:0] wdata,
                         input int block, output int t);
        clear_obs();
        t = cyc;
        dbg.fetch_req = 1'b0;
        applyStimulus(1'b1, wr, tag, way, addr, wdata);
        tick();
        applyStimulus(1'b0, wr, tag, way, addr, wdata);
        finish_op(t, block);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog cycle %0d: got no finish expected finish", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        int fprob;

        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 64'd0);
        dbg.fetch_req        = 1'b0;
        dbg.ic_debug_rd_data = '0;
        rst                  = 1'b1;
        clear_obs();
        @(posedge clk);
        #1;
        cyc = 0;

        // Reset state pinned by hand.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd1, 16'h1111, 64'd0);
        #3;
        cmp("rst_ready",      64'(dbg.req_ready),   64'd0);
        cmp("rst_busy",       64'(dbg.busy),        64'd0);
        cmp("rst_resp_valid", 64'(dbg.resp_valid),  64'd0);
        cmp("rst_stall",      64'(dbg.fetch_stall), 64'd0);
        repeat (3) tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 64'd0);
        rst = 1'b0;
        tick();

        // Uncontended read, data array, way 2.
        dbg.ic_debug_rd_data = 64'hDEAD_BEEF_0000_0001;
        do_op(1'b0, 1'b0, 2'd2, 16'h0123, 64'd0, 0, t);
        cmp("rd_accept_lat", 64'(obs_accept_cyc - t), 64'd0);
        cmp("rd_issue_lat",  64'(obs_rd_en_cyc - t),  64'd2);
        cmp("rd_way_onehot", 64'(obs_way),            64'b0100);
        cmp("rd_resp_lat",   64'(obs_resp_cyc - t),   64'd5);
        cmp("rd_resp_data",  obs_resp_data,           64'hDEAD_BEEF_0000_0001);

        // Uncontended write, tag array, way 0.
        dbg.ic_debug_rd_data = {$urandom, $urandom};
        do_op(1'b1, 1'b1, 2'd0, 16'h0042, 64'h55, 0, t);
        cmp("wr_issue_lat", 64'(obs_wr_en_cyc - t), 64'd2);
        cmp("wr_en_count",  64'(obs_wr_en_cnt),     64'd1);
        cmp("wr_tag",       64'(obs_tag),           64'd1);
        cmp("wr_way",       64'(obs_way),           64'b0001);
        cmp("wr_data",      obs_wdata,              64'h55);
        cmp("wr_resp_lat",  64'(obs_resp_cyc - t),  64'd3);
        cmp("wr_resp_data", obs_resp_data,          64'd0);

        // Fetch holds the port throughout: starvation stall wins.
        dbg.ic_debug_rd_data = {$urandom, $urandom};
        do_op(1'b0, 1'b0, 2'd1, 16'h0456, 64'd0, 1000, t);
        cmp("starve_rise",  64'(obs_stall_rise - t), 64'd10);
        cmp("starve_issue", 64'(obs_rd_en_cyc - t),  64'd11);
        cmp("starve_resp",  64'(obs_resp_cyc - t),   64'd14);
        cmp("starve_fall",  64'(obs_stall_fall),     64'(obs_resp_cyc));

        // Fetch lets go after three blocked cycles; then a fresh full stall.
        do_op(1'b0, 1'b1, 2'd3, 16'h0789, 64'd0, 3, t);
        cmp("partial_issue",    64'(obs_rd_en_cyc - t),  64'd5);
        cmp("partial_no_stall", 64'(obs_stall_rise),     64'hFFFF_FFFF_FFFF_FFFF);
        do_op(1'b1, 1'b0, 2'd2, 16'h0abc, 64'h1234, 1000, t);
        cmp("counter_cleared",  64'(obs_stall_rise - t), 64'd10);

        // Request pulsed during RD_WAIT is dropped; back-to-back accept.
        clear_obs();
        t = cyc;
        dbg.ic_debug_rd_data = 64'h0BAD_F00D_CAFE_0002;
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd3, 16'h0200, 64'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd3, 16'h0200, 64'd0);
        tick();
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 16'h0300, 64'h77);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 64'd0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 16'h0301, 64'h88);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 64'd0);
        finish_op(cyc - 1, 0);
        cmp("b2b_first_resp", 64'(obs_first_resp - t), 64'd5);
        cmp("b2b_accept",     64'(obs_accept_cyc - t),  64'd5);
        cmp("ignored_resps",  64'(obs_resp_cnt),        64'd2);
        cmp("ignored_writes", 64'(obs_wr_en_cnt),       64'd1);
        cmp("b2b_wdata",      obs_wdata,                64'h88);

        // Reset while waiting for read data.
        clear_obs();
        t = cyc;
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 16'h0555, 64'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #3;
        cmp("rstmid_busy",  64'(dbg.busy),           64'd0);
        cmp("rstmid_ready", 64'(dbg.req_ready),      64'd1);
        cmp("rstmid_rden",  64'(dbg.ic_debug_rd_en), 64'd0);
        cmp("rstmid_stall", 64'(dbg.fetch_stall),    64'd0);
        cmp("rstmid_rdata", dbg.resp_rdata,          64'd0);
        repeat (6) tick();
        cmp("rstmid_no_resp", 64'(obs_resp_cnt), 64'd0);

        // Randomized traffic, fetch pressure and occasional resets.
        fprob = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                case ($urandom_range(0, 3))
                    0:       fprob = 0;
                    1:       fprob = 50;
                    2:       fprob = 85;
                    default: fprob = 100;
                endcase
            end
            rst = ($urandom_range(0, 299) == 0);
            applyStimulus(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          16'($urandom), {$urandom, $urandom});
            dbg.fetch_req        = ($urandom_range(0, 99) < fprob);
            dbg.ic_debug_rd_data = {$urandom, $urandom};
            tick();
        end
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 64'd0);
        dbg.fetch_req = 1'b0;
        repeat (30) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
